// File: rtl/pe_mult_seq.sv
// Iterative 32-lane signed multiplier: radix-2 shift-add over DATA_W cycles,
// producing the packed per-lane product vector under a valid/ready handshake.
module pe_mult_seq #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_W-1:0]       neuron,
  input  logic [LANES*DATA_W-1:0]       weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*2*DATA_W-1:0]     mult_result
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int STEP_W = $clog2(DATA_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state;
  logic [STEP_W-1:0]         step;
  logic [LANES*DATA_W-1:0]   neuron_q;
  logic [LANES*DATA_W-1:0]   weight_q;
  logic [LANES*PROD_W-1:0]   acc_q;
  logic [LANES*PROD_W-1:0]   acc_next;
  logic                      accept;
  logic                      last_step;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (step == LAST_STEP);

  // Weight MSB carries -2^(DATA_W-1), so the final step subtracts instead of adds.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] acc_lane;
    logic [DATA_W-1:0] w_lane;
    logic              w_bit;

    assign a_ext    = {{DATA_W{neuron_q[j*DATA_W+DATA_W-1]}}, neuron_q[j*DATA_W +: DATA_W]};
    assign w_lane   = weight_q[j*DATA_W +: DATA_W];
    assign w_bit    = w_lane[step];
    assign addend   = a_ext << step;
    assign acc_lane = acc_q[j*PROD_W +: PROD_W];
    assign acc_next[j*PROD_W +: PROD_W] = !w_bit    ? acc_lane :
                                          last_step ? acc_lane - addend :
                                                      acc_lane + addend;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      mult_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_BUSY;
            step  <= '0;
          end
        end
        S_BUSY: begin
          if (last_step) begin
            mult_result <= acc_next;
            state       <= S_DONE;
            step        <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: operand and accumulator registers carry no reset; they are always
  // loaded or cleared on accept before being read, which keeps the wide
  // datapath free of reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      neuron_q <= neuron;
      weight_q <= weight;
      acc_q    <= '0;
    end else if (state == S_BUSY) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: tb/tb_pe_mult_seq.sv
// Scoreboard bench for pe_mult_seq: stimulus pushes reference products into a
// queue, an independent monitor pops and compares on each consumed result.
module tb_pe_mult_seq;

  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int PW     = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*DATA_W-1:0]  neuron;
  logic [LANES*DATA_W-1:0]  weight;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*PW-1:0]      mult_result;

  always #5 clk = ~clk;

  pe_mult_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .neuron     (neuron),
    .weight     (weight),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mult_result(mult_result)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int txn      = 0;
  int mode     = 2;   // 0: random out_ready, 1: always ready, 2: stalled
  int last_consume = 0;
  logic prev_ov = 1'b0;
  logic [LANES*PW-1:0] last_result = '0;

  logic [LANES*PW-1:0] exp_q[$];
  longint              dot_q[$];
  int                  edge_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name, input logic [LANES*PW-1:0] got,
                             input logic [LANES*PW-1:0] exp);
    int bad = 0;
    for (int j = 0; j < LANES; j++) begin
      if (got[j*PW +: PW] !== exp[j*PW +: PW]) begin
        bad = j;
        break;
      end
    end
    check($sformatf("%s lane%0d", name, bad), 64'(got[bad*PW +: PW]), 64'(exp[bad*PW +: PW]));
  endtask

  // Reference: exact signed integer products and their dot product.
  function automatic logic [LANES*PW-1:0] ref_prod(input logic [LANES*DATA_W-1:0] n,
                                                   input logic [LANES*DATA_W-1:0] w);
    logic [LANES*PW-1:0] r;
    int p;
    for (int j = 0; j < LANES; j++) begin
      p = int'($signed(n[j*DATA_W +: DATA_W])) * int'($signed(w[j*DATA_W +: DATA_W]));
      r[j*PW +: PW] = p;
    end
    return r;
  endfunction

  function automatic longint ref_dot(input logic [LANES*DATA_W-1:0] n,
                                     input logic [LANES*DATA_W-1:0] w);
    longint s = 0;
    for (int j = 0; j < LANES; j++)
      s += longint'($signed(n[j*DATA_W +: DATA_W])) * longint'($signed(w[j*DATA_W +: DATA_W]));
    return s;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] rand_vec();
    logic [LANES*DATA_W-1:0] v;
    for (int j = 0; j < LANES; j++) begin
      case ($urandom_range(0, 7))
        0:       v[j*DATA_W +: DATA_W] = 16'h8000;
        1:       v[j*DATA_W +: DATA_W] = 16'h7fff;
        2:       v[j*DATA_W +: DATA_W] = 16'h0000;
        3:       v[j*DATA_W +: DATA_W] = 16'hffff;
        default: v[j*DATA_W +: DATA_W] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] splat(input logic [DATA_W-1:0] x);
    logic [LANES*DATA_W-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*DATA_W +: DATA_W] = x;
    return v;
  endfunction

  // Presents one operand pair, holds it until accepted, then scrambles the
  // operand bus so later changes must be ignored by the block.
  task automatic send(input logic [LANES*DATA_W-1:0] n, input logic [LANES*DATA_W-1:0] w,
                      output int accept_edge);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    neuron   = n;
    weight   = w;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    accept_edge = cyc + 1;
    if (!in_ready) begin
      check("accept timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_prod(n, w));
      dot_q.push_back(ref_dot(n, w));
      edge_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      neuron   = rand_vec();
      weight   = rand_vec();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      dot_q.delete();
      edge_q.delete();
    end
  endtask

  // Monitor: drives out_ready, checks latency on each rise and the result on each consume.
  initial begin
    longint dut_dot;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (!rst) begin
        if (out_valid && !prev_ov) begin
          if (edge_q.size() == 0) check("unexpected out_valid", 64'(out_valid), 64'd0);
          else check($sformatf("latency txn%0d", txn), 64'(cyc - edge_q[0]), 64'd16);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("result without request", 64'(out_valid), 64'd0);
          end else begin
            check_lanes($sformatf("txn%0d", txn), mult_result, exp_q[0]);
            dut_dot = 0;
            for (int j = 0; j < LANES; j++)
              dut_dot += longint'($signed(mult_result[j*PW +: PW]));
            check($sformatf("dot txn%0d", txn), 64'(dut_dot), 64'(dot_q[0]));
            last_result  = mult_result;
            last_consume = cyc + 1;
            void'(exp_q.pop_front());
            void'(dot_q.pop_front());
            void'(edge_q.pop_front());
            txn++;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_a, e_b, t;
    logic [LANES*DATA_W-1:0] n, w;
    logic [LANES*PW-1:0] snap;

    rst = 1'b1; in_valid = 1'b0; neuron = '0; weight = '0;
    repeat (3) @(negedge clk);
    check("in_ready during reset", 64'(in_ready), 64'd0);
    check("out_valid after reset", 64'(out_valid), 64'd0);
    check("mult_result after reset", 64'(|mult_result), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);
    mode = 1;

    // Basic: 3 x 5 in every lane.
    send(splat(16'd3), splat(16'd5), e_a);
    drain();
    check_lanes("basic", last_result, {LANES{32'h0000000F}});

    // Sign corners in lanes 0..5, random elsewhere.
    n = rand_vec(); w = rand_vec();
    n[0*16 +: 16] = 16'h8000; w[0*16 +: 16] = 16'h8000;
    n[1*16 +: 16] = 16'h8000; w[1*16 +: 16] = 16'h7fff;
    n[2*16 +: 16] = 16'h7fff; w[2*16 +: 16] = 16'h7fff;
    n[3*16 +: 16] = 16'hfffd; w[3*16 +: 16] = 16'h0005;
    n[4*16 +: 16] = 16'hffff; w[4*16 +: 16] = 16'hffff;
    n[5*16 +: 16] = 16'h0000; w[5*16 +: 16] = 16'h8000;
    send(n, w, e_a);
    drain();
    check("corner lane0", 64'(last_result[0*32 +: 32]), 64'h40000000);
    check("corner lane1", 64'(last_result[1*32 +: 32]), 64'hC0008000);
    check("corner lane2", 64'(last_result[2*32 +: 32]), 64'h3FFF0001);
    check("corner lane3", 64'(last_result[3*32 +: 32]), 64'hFFFFFFF1);
    check("corner lane4", 64'(last_result[4*32 +: 32]), 64'h00000001);
    check("corner lane5", 64'(last_result[5*32 +: 32]), 64'h00000000);

    // Backpressure: result held for 10 cycles while a new request waits.
    mode = 2;
    send(rand_vec(), rand_vec(), e_a);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp out_valid rose", 64'(out_valid), 64'd1);
    snap = mult_result;
    n = rand_vec(); w = rand_vec();
    in_valid = 1'b1; neuron = n; weight = w;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp out_valid c%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("bp result held c%0d", i), 64'(mult_result === snap), 64'd1);
      check($sformatf("bp in_ready c%0d", i), 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    mode = 1;
    send(n, w, e_b);
    check("bp accept after release", 64'(e_b - last_consume), 64'd1);
    drain();

    // Back-to-back with out_ready high: 18-cycle accept spacing.
    send(rand_vec(), rand_vec(), e_a);
    send(rand_vec(), rand_vec(), e_b);
    check("back-to-back spacing", 64'(e_b - e_a), 64'd18);
    drain();

    // Reset during step 7 aborts the operation.
    send(rand_vec(), rand_vec(), e_a);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort mult_result", 64'(|mult_result), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    exp_q.delete(); dot_q.delete(); edge_q.delete();
    send(splat(16'd100), splat(-16'sd200), e_a);
    drain();
    check_lanes("after abort", last_result, {LANES{32'hFFFFB1E0}});

    // Random traffic with random input gaps and output stalls.
    mode = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rand_vec(), rand_vec(), e_a);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
